// File: rtl/sensor_hub_pkg.sv
// Shared constants, frame layout and FSM state type for the sensor_hub request/response front end.
package sensor_hub_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_STATUS = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_TEMP   = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_HUM    = 8'h02;

  localparam logic [BYTE_W-1:0] RSP_OK       = 8'h08;
  localparam logic [BYTE_W-1:0] RSP_TEMP     = 8'h09;
  localparam logic [BYTE_W-1:0] RSP_HUM      = 8'h0A;
  localparam logic [BYTE_W-1:0] RSP_SENS_ERR = 8'hFF;
  localparam logic [BYTE_W-1:0] RSP_CHK_ERR  = 8'hFE;
  localparam logic [BYTE_W-1:0] RSP_BAD_ADDR = 8'hFD;
  localparam logic [BYTE_W-1:0] RSP_BAD_CMD  = 8'hFC;

  localparam int unsigned HUM_INT_OFS  = 32;
  localparam int unsigned HUM_FLT_OFS  = 24;
  localparam int unsigned TEMP_INT_OFS = 16;
  localparam int unsigned TEMP_FLT_OFS = 8;
  localparam int unsigned CHK_OFS      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_RESPOND
  } state_e;

  function automatic logic cmd_is_valid(input logic [BYTE_W-1:0] cmd);
    return (cmd == CMD_STATUS) || (cmd == CMD_TEMP) || (cmd == CMD_HUM);
  endfunction

endpackage

// File: rtl/sensor_frame_check.sv
// Combinational field extraction and checksum flag for one sensor frame.
// Checksum comparison is only built when SENSOR_HUB_CHECKSUM_EN is defined.
module sensor_frame_check
  import sensor_hub_pkg::*;
#(
  parameter int unsigned FRAME_W = 40
) (
  input  logic [FRAME_W-1:0] frame_i,
  output logic [BYTE_W-1:0]  hum_int_c_o,
  output logic [BYTE_W-1:0]  temp_int_c_o,
  output logic               chk_ok_c_o
);

  logic [BYTE_W-1:0] hum_flt;
  logic [BYTE_W-1:0] temp_flt;
  logic [BYTE_W-1:0] chk;

  assign hum_int_c_o  = frame_i[HUM_INT_OFS  +: BYTE_W];
  assign hum_flt      = frame_i[HUM_FLT_OFS  +: BYTE_W];
  assign temp_int_c_o = frame_i[TEMP_INT_OFS +: BYTE_W];
  assign temp_flt     = frame_i[TEMP_FLT_OFS +: BYTE_W];
  assign chk          = frame_i[CHK_OFS      +: BYTE_W];

`ifdef SENSOR_HUB_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;

  // Byte-wide sum wraps naturally, giving the mod-256 checksum.
  assign sum        = hum_int_c_o + hum_flt + temp_int_c_o + temp_flt;
  assign chk_ok_c_o = (sum == chk);
`else
  logic unused_fields;

  assign unused_fields = ^{hum_flt, temp_flt, chk};
  assign chk_ok_c_o    = 1'b1;
`endif

endmodule

// File: rtl/sensor_hub.sv
// Request/response front end: starts one addressed sensor channel, waits for its frame
// with a timeout and returns a registered response. Optional checksum: SENSOR_HUB_CHECKSUM_EN.
module sensor_hub
  import sensor_hub_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned FRAME_W        = 40
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [BYTE_W-1:0]              request_command,
  input  logic [BYTE_W-1:0]              request_address,
  output logic [NUM_SENSORS-1:0]         sensor_start,
  input  logic [NUM_SENSORS-1:0]         sensor_done,
  input  logic [NUM_SENSORS-1:0]         sensor_error,
  input  logic [NUM_SENSORS*FRAME_W-1:0] sensor_frame,
  output logic                           response_valid,
  input  logic                           response_ready,
  output logic [BYTE_W-1:0]              response_command,
  output logic [BYTE_W-1:0]              response_value,
  output logic                           busy
);

  localparam int unsigned SEL_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e                   state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [BYTE_W-1:0]        cmd_q, cmd_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic [BYTE_W-1:0]        rsp_cmd_q, rsp_cmd_d;
  logic [BYTE_W-1:0]        rsp_val_q, rsp_val_d;
  logic [NUM_SENSORS-1:0]   start_q, start_d;
  logic                     req_ready_q, busy_q, rsp_valid_q;
  logic [FRAME_W-1:0]       frames [NUM_SENSORS];
  logic [BYTE_W-1:0]        hum_int, temp_int;
  logic                     chk_ok;

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_frames
    assign frames[g] = sensor_frame[g*FRAME_W +: FRAME_W];
  end

  sensor_frame_check #(
    .FRAME_W (FRAME_W)
  ) u_frame_check (
    .frame_i      (frame_q),
    .hum_int_c_o  (hum_int),
    .temp_int_c_o (temp_int),
    .chk_ok_c_o   (chk_ok)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    rsp_cmd_d = rsp_cmd_q;
    rsp_val_d = rsp_val_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_d = SEL_W'(request_address);
          cmd_d = request_command;
          if (32'(request_address) >= NUM_SENSORS) begin
            state_d   = ST_RESPOND;
            rsp_cmd_d = RSP_BAD_ADDR;
            rsp_val_d = '0;
          end else if (!cmd_is_valid(request_command)) begin
            state_d   = ST_RESPOND;
            rsp_cmd_d = RSP_BAD_CMD;
            rsp_val_d = '0;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Channel events outrank the timeout that expires on the same cycle.
        if (sensor_error[sel_q]) begin
          state_d   = ST_RESPOND;
          rsp_cmd_d = RSP_SENS_ERR;
          rsp_val_d = '0;
        end else if (sensor_done[sel_q]) begin
          frame_d = frames[sel_q];
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_RESPOND;
          rsp_cmd_d = RSP_SENS_ERR;
          rsp_val_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        state_d   = ST_RESPOND;
        rsp_val_d = '0;
        if (!chk_ok) begin
          rsp_cmd_d = RSP_CHK_ERR;
        end else begin
          case (cmd_q)
            CMD_STATUS: rsp_cmd_d = RSP_OK;
            CMD_TEMP: begin
              rsp_cmd_d = RSP_TEMP;
              rsp_val_d = temp_int;
            end
            CMD_HUM: begin
              rsp_cmd_d = RSP_HUM;
              rsp_val_d = hum_int;
            end
            default: rsp_cmd_d = RSP_BAD_CMD;
          endcase
        end
      end
      ST_RESPOND: begin
        if (response_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_SENSORS; i++) begin
      start_d[i] = (state_d == ST_START) && (sel_d == SEL_W'(i));
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      rsp_cmd_q   <= '0;
      rsp_val_q   <= '0;
      start_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_val_q   <= rsp_val_d;
      start_q     <= start_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESPOND);
    end
  end

  assign req_ready        = req_ready_q;
  assign busy             = busy_q;
  assign sensor_start     = start_q;
  assign response_valid   = rsp_valid_q;
  assign response_command = rsp_cmd_q;
  assign response_value   = rsp_val_q;

endmodule

// File: tb/tb_sensor_hub.sv
// Self-checking bench for sensor_hub: vector table plus hand-written timing sequences,
// with expected responses queued on a scoreboard when each request is driven.
module tb_sensor_hub;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned FW = 40;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [39:0] frame;
    int          ev;      // 0 none, 1 done, 2 error, 3 error+done plus foreign done
    logic        start;
    logic [7:0]  exp_cmd;
    logic [7:0]  exp_val;
  } vec_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] val;
  } rsp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        request_command;
  logic [7:0]        request_address;
  logic [NS-1:0]     sensor_start;
  logic [NS-1:0]     sensor_done;
  logic [NS-1:0]     sensor_error;
  logic [NS*FW-1:0]  sensor_frame;
  logic              response_valid;
  logic              response_ready;
  logic [7:0]        response_command;
  logic [7:0]        response_value;
  logic              busy;

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t sb[$];
  vec_t vt[13];

  always #5 clock = ~clock;

  sensor_hub #(
    .NUM_SENSORS    (NS),
    .TIMEOUT_CYCLES (TO),
    .FRAME_W        (FW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .request_command  (request_command),
    .request_address  (request_address),
    .sensor_start     (sensor_start),
    .sensor_done      (sensor_done),
    .sensor_error     (sensor_error),
    .sensor_frame     (sensor_frame),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .response_command (response_command),
    .response_value   (response_value),
    .busy             (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_frame(input logic [7:0] addr, input logic [39:0] frame);
    for (int i = 0; i < NS; i++) sensor_frame[i*FW +: FW] = FW'({$urandom, $urandom});
    if (addr < NS) sensor_frame[int'(addr)*FW +: FW] = frame;
  endtask

  task automatic drive_req(input logic [7:0] cmd, input logic [7:0] addr);
    req_valid       = 1'b1;
    request_command = cmd;
    request_address = addr;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int lat);
    lat = 0;
    while (response_valid !== 1'b1 && lat < max) begin
      step();
      lat++;
    end
    if (response_valid !== 1'b1) lat = -1;
  endtask

  task automatic check_rsp(input string name);
    rsp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: response seen, expected none queued", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " cmd"}, 64'(response_command), 64'(e.cmd));
    chk({name, " val"}, 64'(response_value), 64'(e.val));
  endtask

  task automatic accept_rsp(input string name);
    response_ready = 1'b1;
    step();
    response_ready = 1'b0;
    chk({name, " valid drop"}, 64'(response_valid), 64'(0));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            lat;
    logic [NS-1:0] es;
    string         nm;
    nm = $sformatf("vec%0d", idx);
    set_frame(v.addr, v.frame);
    sb.push_back('{v.exp_cmd, v.exp_val});
    chk({nm, " ready idle"}, 64'(req_ready), 64'(1));
    drive_req(v.cmd, v.addr);
    chk({nm, " busy"}, 64'(busy), 64'(1));
    if (v.start) begin
      es = '0;
      es[v.addr] = 1'b1;
      chk({nm, " start"}, 64'(sensor_start), 64'(es));
      step();
      chk({nm, " start one cycle"}, 64'(sensor_start), 64'(0));
      if (v.ev != 0) begin
        if (v.ev == 1 || v.ev == 3) sensor_done[v.addr] = 1'b1;
        if (v.ev == 2 || v.ev == 3) sensor_error[v.addr] = 1'b1;
        if (v.ev == 3) sensor_done[(int'(v.addr) + 1) % NS] = 1'b1;
        step();
        sensor_done  = '0;
        sensor_error = '0;
      end
      wait_rsp(TO + 4, lat);
      if (lat < 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s response timeout: got none, expected response", nm);
        return;
      end
    end else begin
      chk({nm, " no start"}, 64'(sensor_start), 64'(0));
      chk({nm, " valid next cycle"}, 64'(response_valid), 64'(1));
    end
    check_rsp(nm);
    accept_rsp(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic bad;
    rsp_t e;

    vt[0]  = '{8'h01, 8'd2,   40'h3700190050, 1, 1'b1, 8'h09, 8'h19};
`ifdef SENSOR_HUB_CHECKSUM_EN
    vt[1]  = '{8'h02, 8'd0,   40'h3700190051, 1, 1'b1, 8'hFE, 8'h00};
`else
    vt[1]  = '{8'h02, 8'd0,   40'h3700190051, 1, 1'b1, 8'h0A, 8'h37};
`endif
    vt[2]  = '{8'h00, 8'd1,   40'h11223344AA, 1, 1'b1, 8'h08, 8'h00};
    vt[3]  = '{8'h02, 8'd3,   40'h2A05170349, 1, 1'b1, 8'h0A, 8'h2A};
    vt[4]  = '{8'h01, 8'd4,   40'h0,          0, 1'b0, 8'hFD, 8'h00};
    vt[5]  = '{8'h07, 8'd0,   40'h0,          0, 1'b0, 8'hFC, 8'h00};
    vt[6]  = '{8'h07, 8'd9,   40'h0,          0, 1'b0, 8'hFD, 8'h00};
    vt[7]  = '{8'h01, 8'd1,   40'h3700190050, 2, 1'b1, 8'hFF, 8'h00};
    vt[8]  = '{8'h01, 8'd1,   40'h3700190050, 3, 1'b1, 8'hFF, 8'h00};
`ifdef SENSOR_HUB_CHECKSUM_EN
    vt[9]  = '{8'h01, 8'd3,   40'h3C0A1E05FF, 1, 1'b1, 8'hFE, 8'h00};
`else
    vt[9]  = '{8'h01, 8'd3,   40'h3C0A1E05FF, 1, 1'b1, 8'h09, 8'h1E};
`endif
    vt[10] = '{8'h01, 8'd0,   40'hC864320A68, 1, 1'b1, 8'h09, 8'h32};
    vt[11] = '{8'h03, 8'd2,   40'h0,          0, 1'b0, 8'hFC, 8'h00};
    vt[12] = '{8'h00, 8'hFF,  40'h0,          0, 1'b0, 8'hFD, 8'h00};

    reset = 1'b1;
    req_valid = 1'b0;
    request_command = '0;
    request_address = '0;
    sensor_done = '0;
    sensor_error = '0;
    sensor_frame = '0;
    response_ready = 1'b0;
    step();
    step();
    chk("reset req_ready", 64'(req_ready), 64'(1));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset start", 64'(sensor_start), 64'(0));
    chk("reset valid", 64'(response_valid), 64'(0));
    chk("reset cmd", 64'(response_command), 64'(0));
    chk("reset val", 64'(response_value), 64'(0));
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

    // Timeout with foreign channel activity that must be ignored.
    set_frame(8'd1, 40'h3700190050);
    sb.push_back('{8'hFF, 8'h00});
    drive_req(8'h01, 8'd1);
    chk("to start", 64'(sensor_start), 64'(4'b0010));
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c == 3) begin
        sensor_done[0]  = 1'b1;
        sensor_error[2] = 1'b1;
      end
      step();
      sensor_done  = '0;
      sensor_error = '0;
      if (response_valid === 1'b1) lat = c;
    end
    chk("timeout latency", 64'(lat), 64'(17));
    if (lat > 0) check_rsp("timeout");
    accept_rsp("timeout");

    // Done on the final timeout cycle wins, and takes 2 cycles to respond.
    set_frame(8'd3, 40'h2A05170349);
    sb.push_back('{8'h09, 8'h17});
    drive_req(8'h01, 8'd3);
    for (int c = 1; c <= 16; c++) step();
    chk("edge no early valid", 64'(response_valid), 64'(0));
    sensor_done[3] = 1'b1;
    step();
    sensor_done = '0;
    chk("edge check cycle", 64'(response_valid), 64'(0));
    step();
    chk("edge valid", 64'(response_valid), 64'(1));
    if (response_valid === 1'b1) check_rsp("edge");
    accept_rsp("edge");

    // Backpressure, then a request held during the handshake cycle.
    sb.push_back('{8'hFC, 8'h00});
    drive_req(8'h07, 8'd0);
    e = sb[0];
    check_rsp("bp");
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (response_valid !== 1'b1 || response_command !== e.cmd || response_value !== e.val)
        bad = 1'b1;
    end
    chk("bp stable", 64'(bad), 64'(0));
    sb.push_back('{8'hFD, 8'h00});
    req_valid       = 1'b1;
    request_command = 8'h01;
    request_address = 8'd5;
    response_ready  = 1'b1;
    step();
    response_ready = 1'b0;
    chk("b2b not accepted valid", 64'(response_valid), 64'(0));
    chk("b2b idle ready", 64'(req_ready), 64'(1));
    step();
    req_valid = 1'b0;
    chk("b2b valid", 64'(response_valid), 64'(1));
    check_rsp("b2b");
    accept_rsp("b2b");

    // Reset during WAIT aborts with no response.
    set_frame(8'd0, 40'h3700190050);
    drive_req(8'h02, 8'd0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort req_ready", 64'(req_ready), 64'(1));
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort start", 64'(sensor_start), 64'(0));
    chk("abort valid", 64'(response_valid), 64'(0));
    chk("abort cmd", 64'(response_command), 64'(0));
    chk("abort val", 64'(response_value), 64'(0));
    sensor_done[0] = 1'b1;
    step();
    sensor_done = '0;
    bad = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (response_valid !== 1'b0 || sensor_start !== '0) bad = 1'b1;
      step();
    end
    chk("abort silent", 64'(bad), 64'(0));

    chk("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
